// File: rtl/packet_parser.sv
// rtl/packet_parser.sv - byte-stream packet parser assembling 32-bit operand words
module packet_parser #(
    parameter int max_words_p = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  opcode_o,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        word_last_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE,
        RSV,
        LEN_LO,
        LEN_HI,
        DATA,
        EMIT,
        DRAIN
    } state_t;

    localparam logic [15:0] MaxWords = 16'(max_words_p);

    state_t      state;
    state_t      state_n;
    logic [7:0]  rsv_q;
    logic [7:0]  len_lo_q;
    logic [15:0] drain_q;
    logic [13:0] words_q;
    logic [1:0]  byte_q;
    logic [31:0] word_q;
    logic [7:0]  opcode_q;
    logic        err_q;

    logic        rx_fire;
    logic        word_fire;
    logic [15:0] length;
    logic [15:0] n_words;
    logic        bad_hdr;

    // Upstream is only stalled while a finished word waits for the ALU.
    assign rx_ready_o   = (state != EMIT);
    assign word_valid_o = (state == EMIT);
    assign word_last_o  = (state == EMIT) && (words_q == 14'd1);
    assign word_o       = word_q;
    assign opcode_o     = opcode_q;
    assign err_o        = err_q;

    assign rx_fire   = rx_valid_i && rx_ready_o;
    assign word_fire = word_valid_o && word_ready_i;

    // Length is only meaningful while the MSB byte is on rx_data_i in LEN_HI.
    assign length  = {rx_data_i, len_lo_q};
    assign n_words = {2'b00, length[15:2]} - 16'd1;
    assign bad_hdr = (rsv_q != 8'h00) || (length < 16'd8) ||
                     (length[1:0] != 2'b00) || (n_words > MaxWords);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: header walks one state per byte, then words or drain.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (rx_fire) state_n = RSV;
            RSV:    if (rx_fire) state_n = LEN_LO;
            LEN_LO: if (rx_fire) state_n = LEN_HI;
            LEN_HI: if (rx_fire) state_n = bad_hdr ? DRAIN : DATA;
            DATA:   if (rx_fire && (byte_q == 2'd3)) state_n = EMIT;
            EMIT:   if (word_fire) state_n = word_last_o ? IDLE : DATA;
            DRAIN: begin
                if (drain_q == 16'd0) begin
                    state_n = IDLE;
                end else if (rx_fire && (drain_q == 16'd1)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Header fields, operand assembly, word/drain counters and the error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsv_q    <= 8'h00;
            len_lo_q <= 8'h00;
            drain_q  <= 16'd0;
            words_q  <= 14'd0;
            byte_q   <= 2'd0;
            word_q   <= 32'd0;
            opcode_q <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE:   if (rx_fire) opcode_q <= rx_data_i;
                RSV:    if (rx_fire) rsv_q <= rx_data_i;
                LEN_LO: if (rx_fire) len_lo_q <= rx_data_i;
                LEN_HI: begin
                    if (rx_fire) begin
                        if (bad_hdr) begin
                            err_q   <= 1'b1;
                            drain_q <= (length > 16'd4) ? (length - 16'd4) : 16'd0;
                        end else begin
                            words_q <= n_words[13:0];
                            byte_q  <= 2'd0;
                        end
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        word_q <= {word_q[23:0], rx_data_i};
                        byte_q <= byte_q + 2'd1;
                    end
                end
                EMIT:  if (word_fire) words_q <= words_q - 14'd1;
                DRAIN: if (rx_fire && (drain_q != 16'd0)) drain_q <= drain_q - 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_parser.sv
// tb/tb_packet_parser.sv - self-checking bench for packet_parser
module tb_packet_parser;

    typedef struct packed {
        logic [31:0] w;
        logic        l;
        logic [7:0]  op;
    } wrec_t;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  rsv;
        logic [15:0] len;
        int          nb;
        logic [7:0]  seed;
        int          exp_err;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_final;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  opcode;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        word_last;
    logic        err;

    int    checks = 0;
    int    failures = 0;
    int    err_cnt = 0;
    wrec_t wq[$];
    vec_t  vecs[7];

    always #5 clk = ~clk;

    packet_parser #(.max_words_p(3)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready),
        .opcode_o     (opcode),
        .word_o       (word),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready),
        .word_last_o  (word_last),
        .err_o        (err)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) wq.push_back({word, word_last, opcode});
            if (err) err_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte 0x%02h never accepted", b);
        end
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [7:0] rsv, input logic [15:0] len);
        send_byte(op);
        send_byte(rsv);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic clear();
        wq.delete();
        err_cnt = 0;
    endtask

    initial begin
        vecs[0] = '{8'h10, 8'h00, 16'h000C,  8, 8'h20, 0, 2, 32'h20212223, 32'h24252627};
        vecs[1] = '{8'h11, 8'h00, 16'h0009,  5, 8'h30, 1, 0, 32'h0, 32'h0};
        vecs[2] = '{8'h12, 8'h7F, 16'h0008,  4, 8'h50, 1, 0, 32'h0, 32'h0};
        vecs[3] = '{8'h13, 8'h00, 16'h0014, 16, 8'h60, 1, 0, 32'h0, 32'h0};
        vecs[4] = '{8'h14, 8'h00, 16'h0010, 12, 8'h40, 0, 3, 32'h40414243, 32'h48494A4B};
        vecs[5] = '{8'h15, 8'h00, 16'h0004,  0, 8'h00, 1, 0, 32'h0, 32'h0};
        vecs[6] = '{8'h16, 8'h00, 16'h0000,  0, 8'h00, 1, 0, 32'h0, 32'h0};

        repeat (3) tick();
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_last", word_last, 0);
        chk("rst_err", err, 0);
        chk("rst_word", word, 32'h0);
        chk("rst_opcode", opcode, 0);
        rst = 1'b0;
        tick();
        chk("idle_rx_ready", rx_ready, 1);

        // two-word packet, always-ready sink
        clear();
        send_hdr(8'h01, 8'h00, 16'h000C);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        repeat (4) tick();
        chk("p1_count", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("p1_w0", wq[0].w, 32'h12345678);
            chk("p1_l0", wq[0].l, 0);
            chk("p1_w1", wq[1].w, 32'h9ABCDEF0);
            chk("p1_l1", wq[1].l, 1);
            chk("p1_op", wq[1].op, 8'h01);
        end
        chk("p1_err", err_cnt, 0);
        chk("p1_op_held", opcode, 8'h01);

        // stalled sink holds the word and back-pressures upstream
        clear();
        word_ready = 1'b0;
        send_hdr(8'h02, 8'h00, 16'h0008);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", word_valid, 1);
            chk("stall_word", word, 32'hDEADBEEF);
            chk("stall_rx_ready", rx_ready, 0);
            chk("stall_last", word_last, 1);
        end
        @(posedge clk);
        #1;
        word_ready = 1'b1;
        tick();
        chk("stall_done_valid", word_valid, 0);
        chk("stall_done_rx_ready", rx_ready, 1);
        chk("stall_count", wq.size(), 1);
        if (wq.size() == 1) chk("stall_q_word", wq[0].w, 32'hDEADBEEF);

        // short-length header drained, then a good packet
        clear();
        send_hdr(8'h03, 8'h00, 16'h0006);
        chk("bad_err_pulse", err, 1);
        send_byte(8'hAA);
        chk("bad_err_clear", err, 0);
        send_byte(8'hBB);
        send_hdr(8'h04, 8'h00, 16'h0008);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        repeat (4) tick();
        chk("bad_err_cnt", err_cnt, 1);
        chk("bad_next_count", wq.size(), 1);
        if (wq.size() == 1) begin
            chk("bad_next_word", wq[0].w, 32'h00000005);
            chk("bad_next_op", wq[0].op, 8'h04);
            chk("bad_next_last", wq[0].l, 1);
        end

        // table of headers: good, malformed, and word-count boundaries
        for (int v = 0; v < 7; v++) begin
            clear();
            send_hdr(vecs[v].op, vecs[v].rsv, vecs[v].len);
            for (int k = 0; k < vecs[v].nb; k++) send_byte(8'(vecs[v].seed + k));
            repeat (4) tick();
            chk($sformatf("v%0d_err", v), err_cnt, vecs[v].exp_err);
            chk($sformatf("v%0d_count", v), wq.size(), vecs[v].exp_n);
            if (vecs[v].exp_n > 0 && wq.size() == vecs[v].exp_n) begin
                chk($sformatf("v%0d_first", v), wq[0].w, vecs[v].exp_first);
                chk($sformatf("v%0d_first_last", v), wq[0].l, (vecs[v].exp_n == 1) ? 1 : 0);
                chk($sformatf("v%0d_final", v), wq[vecs[v].exp_n-1].w, vecs[v].exp_final);
                chk($sformatf("v%0d_final_last", v), wq[vecs[v].exp_n-1].l, 1);
                chk($sformatf("v%0d_op", v), wq[vecs[v].exp_n-1].op, vecs[v].op);
            end
            chk($sformatf("v%0d_idle_ready", v), rx_ready, 1);
            chk($sformatf("v%0d_idle_valid", v), word_valid, 0);
        end

        // reset after two operand bytes aborts the packet
        clear();
        send_hdr(8'h05, 8'h00, 16'h0008);
        send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", word_valid, 0);
        chk("midrst_opcode", opcode, 0);
        repeat (2) tick();
        send_hdr(8'h06, 8'h00, 16'h0008);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        repeat (4) tick();
        chk("midrst_err", err_cnt, 0);
        chk("midrst_count", wq.size(), 1);
        if (wq.size() == 1) begin
            chk("midrst_word", wq[0].w, 32'h01020304);
            chk("midrst_op", wq[0].op, 8'h06);
            chk("midrst_last", wq[0].l, 1);
        end

        // reset while a word is pending in EMIT
        clear();
        word_ready = 1'b0;
        send_hdr(8'h07, 8'h00, 16'h0008);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        chk("emitrst_pre_valid", word_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        word_ready = 1'b1;
        repeat (2) tick();
        chk("emitrst_valid", word_valid, 0);
        chk("emitrst_count", wq.size(), 0);
        chk("emitrst_err", err_cnt, 0);
        chk("emitrst_ready", rx_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_parser.md
PACKET_PARSER -- requirements
Module: packet_parser

Interface
REQ-001 SHALL have parameter max_words_p, default 64, meaning the largest accepted operand count per packet (range 1..16383).
REQ-002 SHALL have clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have rx_data_i  input  8  byte from the upstream uart_rx m_axis_tdata.
REQ-005 SHALL have rx_valid_i  input  1  byte valid, from uart_rx m_axis_tvalid.
REQ-006 SHALL have rx_ready_o  output  1  byte accept, to uart_rx m_axis_tready.
REQ-007 SHALL have opcode_o  output  8  opcode of the packet currently being emitted.
REQ-008 SHALL have word_o  output  32  assembled operand word.
REQ-009 SHALL have word_valid_o  output  1  word_o, opcode_o and word_last_o valid.
REQ-010 SHALL have word_ready_i  input  1  downstream ALU accepts the word.
REQ-011 SHALL have word_last_o  output  1  word_o is the final operand of the packet.
REQ-012 SHALL have err_o  output  1  one-cycle pulse on a malformed header.

Function
REQ-013 SHALL transfer a byte only on a cycle where rx_valid_i and rx_ready_o are both 1, and a word only where word_valid_o and word_ready_i are both 1.
REQ-014 SHALL parse the packet as: opcode, reserved byte, length[7:0], length[15:8], then N operands of 4 bytes each, MSB first.
REQ-015 SHALL treat length as the total packet byte count including the 4-byte header, giving N = (length-4)/4.
REQ-016 SHALL implement states IDLE, RSV, LEN_LO, LEN_HI, DATA, EMIT and DRAIN.
REQ-017 SHALL step through the header one state per accepted byte: IDLE->RSV (latch opcode), RSV->LEN_LO (latch reserved byte), LEN_LO->LEN_HI (latch low length byte), LEN_HI->DATA or DRAIN.
REQ-018 SHALL declare the header malformed at LEN_HI when any of the following holds: reserved byte != 0x00, length < 8, length[1:0] != 0, or N > max_words_p.
REQ-019 SHALL, on a malformed header, pulse err_o for exactly the cycle after the length MSB is accepted and enter DRAIN.
REQ-020 SHALL, in DRAIN, discard max(length-4, 0) bytes (rx_ready_o=1) and then return to IDLE; when length <= 4, it SHALL return to IDLE on the next cycle.
REQ-021 SHALL, on a good header, enter DATA with a remaining-word counter of N and a 2-bit byte counter of 0.
REQ-022 SHALL, in DATA, shift each accepted byte into word_o from the MSB downward; on the 4th byte it SHALL enter EMIT.
REQ-023 SHALL hold rx_ready_o=0 in EMIT and 1 in every other state (back-pressure upstream).
REQ-024 SHALL assert word_valid_o exactly in EMIT, i.e. one cycle after the 4th operand byte is accepted.
REQ-025 SHALL hold word_o, opcode_o and word_last_o stable while word_valid_o=1 and word_ready_i=0.
REQ-026 SHALL set word_last_o=1 only when the remaining-word counter equals 1.
REQ-027 SHALL, on a word handshake, decrement the counter and go to IDLE if word_last_o=1, otherwise to DATA.
REQ-028 SHALL have no inter-byte timeout; a stalled packet waits indefinitely.
REQ-029 SHALL hold opcode_o until the next packet's opcode is latched.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, enter IDLE and drive word_valid_o=0, word_last_o=0, err_o=0, word_o=0 and opcode_o=0, then drive rx_ready_o=1 in IDLE.
REQ-031 SHALL let a reset asserted mid-packet (any state, including EMIT with word_valid_o=1) abort the packet with no word emitted and no err_o pulse; bytes that follow are parsed as a new header.

Verification
REQ-032 SHALL pass: bytes 01 00 0C 00 12 34 56 78 9A BC DE F0 with word_ready_i=1 -> word 0x12345678 with last=0, then word 0x9ABCDEF0 with last=1, opcode_o=0x01, err_o never set.
REQ-033 SHALL pass: a single-word packet 02 00 08 00 DE AD BE EF with word_ready_i=0 for 10 cycles -> word_valid_o held with word_o=0xDEADBEEF, rx_ready_o=0 throughout; after ready, return to IDLE.
REQ-034 SHALL pass: bytes 03 00 06 00 AA BB followed by 04 00 08 00 00 00 00 05 -> one err_o pulse, AA and BB discarded, then word 0x00000005 emitted with opcode_o=0x04 and last=1.
REQ-035 SHALL pass: reserved byte 0x7F with length 0x0008 -> err_o pulse, 4 bytes drained, no word emitted.
REQ-036 SHALL pass: N = max_words_p+1 -> err_o pulse and all 4*N operand bytes drained; N = max_words_p -> all words emitted, with the last flagged.
REQ-037 SHALL pass: rst_i for 1 cycle after 2 operand bytes of a packet -> no word_valid_o, and the next clean packet parses correctly.
